pll: RTL and testbench

- Clock generator for the datapath: derives a slower registered clock `clk_out` from `clk_in` by integer division.
- It is a digital divider standing in for a vendor PLL.
- Also provides a one-cycle enable pulse aligned to each `clk_out` rising edge, and a lock indicator.
- Register stages downstream use `clk_out` or `clk_en` as their slow time base.

---
 rtl/pll_pkg.sv | 14 +
 rtl/pll_if.sv | 23 ++
 rtl/pll_lock_detect.sv | 36 +++
 rtl/pll.sv | 92 +++++++++
 tb/tb_pll.sv | 191 +++++++++++++++++++
 5 files changed

// File: rtl/pll_pkg.sv
// Shared constants and helpers for the integer clock divider.
package pll_pkg;

  localparam int DIV_W_DEF       = 16;
  localparam int MIN_DIV         = 2;
  localparam int LOCK_CYCLES_DEF = 16;

  // Ratios below MIN_DIV would give a degenerate (stuck or runt) clock, so
  // they are raised to MIN_DIV. Width-agnostic: callers cast to DIV_W.
  function automatic logic [31:0] clamp_div(input logic [31:0] req);
    return (req < 32'(MIN_DIV)) ? 32'(MIN_DIV) : req;
  endfunction

endpackage

// File: rtl/pll_if.sv
// Control/status bundle of the divider: ratio load in, divided clock,
// enable pulse and lock indication out.
interface pll_if #(
  parameter int DIV_W = 16
);
  logic [DIV_W-1:0] div_val;
  logic             div_load;
  logic             clk_out;
  logic             clk_en;
  logic             locked;

  // Consumer side: programs the ratio, observes the clocks.
  modport master (
    output div_val, div_load,
    input  clk_out, clk_en, locked
  );

  // Divider side.
  modport slave (
    input  div_val, div_load,
    output clk_out, clk_en, locked
  );
endinterface

// File: rtl/pll_lock_detect.sv
// Lock detector: counts output periods (one per clk_en pulse) since the last
// ratio change and reports lock once LOCK_CYCLES periods have been seen.
module pll_lock_detect #(
  parameter int LOCK_CYCLES = 16
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic clk_en_i,
  input  logic chg_i,
  output logic locked_o
);

  localparam int CW = $clog2(LOCK_CYCLES + 1);
  localparam logic [CW-1:0] SAT = CW'(LOCK_CYCLES);
  localparam logic [CW-1:0] ONE = CW'(1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Next count: a ratio change restarts the count; otherwise saturate.
  always_comb begin
    cnt_d = cnt_q;
    if (chg_i)
      cnt_d = '0;
    else if (clk_en_i && (cnt_q != SAT))
      cnt_d = cnt_q + ONE;
  end

  // Period counter register.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign locked_o = (cnt_q == SAT);

endmodule

// File: rtl/pll.sv
// Integer clock divider standing in for a vendor PLL. Produces a registered,
// glitch-free divided clock, an enable pulse on each of its rising edges and
// a lock flag. Ratio changes are deferred to a period boundary so the period
// in flight always completes at the old ratio.
module pll
  import pll_pkg::*;
#(
  parameter int DIV_W       = DIV_W_DEF,
  parameter int DEFAULT_DIV = MIN_DIV,
  parameter int LOCK_CYCLES = LOCK_CYCLES_DEF
) (
  input  logic clk_in,
  input  logic rst_n,
  pll_if.slave bus
);

  localparam logic [DIV_W-1:0] ONE   = DIV_W'(1);
  localparam logic [DIV_W-1:0] N_RST = DIV_W'(DEFAULT_DIV);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [DIV_W-1:0] n_q, n_d;
  logic [DIV_W-1:0] pend_q, pend_d;
  logic             pend_vld_q, pend_vld_d;
  logic             clk_out_q, clk_out_d;
  logic             clk_en_q, clk_en_d;
  logic             bdry;
  logic             apply;
  logic             ratio_chg;

  // Counter advance, boundary detect and pending-ratio bookkeeping. The
  // pending flag is only consulted as registered, so a load landing on a
  // boundary cycle waits for the next boundary.
  always_comb begin
    cnt_d      = (cnt_q == n_q - ONE) ? '0 : cnt_q + ONE;
    bdry       = (cnt_d == '0);
    apply      = bdry && pend_vld_q;
    ratio_chg  = apply && (pend_q != n_q);
    n_d        = n_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (apply) begin
      n_d        = pend_q;
      pend_vld_d = 1'b0;
    end
    // A fresh load wins over the apply that may be consuming the old value.
    if (bus.div_load) begin
      pend_d     = DIV_W'(clamp_div(32'(bus.div_val)));
      pend_vld_d = 1'b1;
    end
  end

  // Output decode from the next count so outputs are straight from flops.
  // At a boundary n_q is still the old ratio, but cnt_d == 0 is below any
  // half-ratio >= 1, so the rising edge is correct for either ratio.
  always_comb begin
    clk_out_d = (cnt_d < (n_q >> 1));
    clk_en_d  = bdry;
  end

  // Divider state and registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      n_q        <= N_RST;
      pend_q     <= N_RST;
      pend_vld_q <= 1'b0;
      clk_out_q  <= 1'b0;
      clk_en_q   <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      n_q        <= n_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      clk_out_q  <= clk_out_d;
      clk_en_q   <= clk_en_d;
    end
  end

  pll_lock_detect #(
    .LOCK_CYCLES (LOCK_CYCLES)
  ) u_lock (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .clk_en_i (clk_en_q),
    .chg_i    (ratio_chg),
    .locked_o (bus.locked)
  );

  assign bus.clk_out = clk_out_q;
  assign bus.clk_en  = clk_en_q;

endmodule

// File: tb/tb_pll.sv
// Directed bench for the clock divider: per-cycle vector tables for startup
// and a ratio switch, plus sequences for clamp, boundary loads, same-value
// reload and asynchronous reset.
module tb_pll;
  import pll_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pll_if #(.DIV_W(16)) bus();

  pll #(.DIV_W(16), .DEFAULT_DIV(2), .LOCK_CYCLES(16)) dut (
    .clk_in (clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic        out;
    logic        en;
    logic        lock;
  } vec_t;

  vec_t v_start[8];
  vec_t v_sw[7];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic run_vec(input vec_t v, input string tag, input int i);
    bus.div_load = v.ld;
    bus.div_val  = v.val;
    step();
    bus.div_load = 1'b0;
    chk($sformatf("%s[%0d].clk_out", tag, i), 32'(bus.clk_out), 32'(v.out));
    chk($sformatf("%s[%0d].clk_en", tag, i),  32'(bus.clk_en),  32'(v.en));
    chk($sformatf("%s[%0d].locked", tag, i),  32'(bus.locked),  32'(v.lock));
  endtask

  task automatic load(input logic [15:0] val);
    bus.div_load = 1'b1;
    bus.div_val  = val;
    step();
    bus.div_load = 1'b0;
  endtask

  // Measures one full output period starting at the next clk_en sample
  // (the current sample counts if clk_en is already high).
  task automatic measure(input string name, input int exp_per, input int exp_hi);
    int g = 0, per = 0, hi = 0;
    while (!bus.clk_en && g < 64) begin step(); g++; end
    chk({name, ".start"}, 32'(bus.clk_en), 32'd1);
    do begin
      hi += int'(bus.clk_out);
      step();
      per++;
    end while (!bus.clk_en && per < 64);
    chk({name, ".period"}, 32'(per), 32'(exp_per));
    chk({name, ".high"},   32'(hi),  32'(exp_hi));
  endtask

  task automatic wait_locked(output int n, input int lim);
    n = 0;
    while (!bus.locked && n < lim) begin step(); n++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int n, gap, drops;

    // Startup after reset with DEFAULT_DIV = 2.
    v_start[0] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    v_start[1] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0};
    v_start[2] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    v_start[3] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0};
    v_start[4] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    v_start[5] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0};
    v_start[6] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    v_start[7] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0};
    // Switch 2 -> 5 from edge 35: one more N=2 period, then high 2 / low 3.
    v_sw[0] = '{1'b1, 16'd5, 1'b0, 1'b0, 1'b1};
    v_sw[1] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0};
    v_sw[2] = '{1'b0, 16'd0, 1'b1, 1'b0, 1'b0};
    v_sw[3] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    v_sw[4] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    v_sw[5] = '{1'b0, 16'd0, 1'b0, 1'b0, 1'b0};
    v_sw[6] = '{1'b0, 16'd0, 1'b1, 1'b1, 1'b0};

    bus.div_load = 1'b0;
    bus.div_val  = '0;

    // Reset state.
    repeat (5) step();
    chk("rst.clk_out", 32'(bus.clk_out), 32'd0);
    chk("rst.clk_en",  32'(bus.clk_en),  32'd0);
    chk("rst.locked",  32'(bus.locked),  32'd0);
    rst_n = 1'b1;
    cyc = 0;

    for (int i = 0; i < 8; i++) run_vec(v_start[i], "start", i);

    // 16 pulses after edges 2..32; count reaches 16 on edge 33.
    repeat (24) step();
    chk("lock_edge32", 32'(bus.locked), 32'd0);
    step();
    chk("lock_edge33", 32'(bus.locked), 32'd1);
    step();
    chk("edge34.clk_en", 32'(bus.clk_en), 32'd1);

    // Odd ratio.
    for (int i = 0; i < 7; i++) run_vec(v_sw[i], "sw5", i);
    wait_locked(n, 200);
    chk("relock5.cycles", 32'(n), 32'd71);
    measure("div5", 5, 2);

    // Clamp: 0 then 1, last wins, both clamp to 2.
    load(16'd0);
    load(16'd1);
    measure("clamp_a", 2, 1);
    chk("clamp.unlocked", 32'(bus.locked), 32'd0);
    measure("clamp_b", 2, 1);

    // Load 4 on a boundary, then 8 the next cycle.
    step();
    bus.div_load = 1'b1;
    bus.div_val  = 16'd4;
    step();
    chk("bdry_load.clk_en", 32'(bus.clk_en), 32'd1);
    load(16'd8);
    gap = 1;
    while (!bus.clk_en && gap < 32) begin step(); gap++; end
    chk("bdry_load.old_period", 32'(gap), 32'd2);
    measure("div8", 8, 4);

    // Same-value reload keeps lock.
    load(16'd6);
    wait_locked(n, 400);
    chk("lock6", 32'(bus.locked), 32'd1);
    measure("div6_a", 6, 3);
    load(16'd6);
    drops = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (!bus.locked) drops++;
    end
    chk("reload.lock_drops", 32'(drops), 32'd0);
    measure("div6_b", 6, 3);

    // Async reset mid-period while clk_out is high and a load is pending.
    n = 0;
    while (!bus.clk_en && n < 16) begin step(); n++; end
    load(16'd9);
    chk("pre_rst.clk_out", 32'(bus.clk_out), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst.clk_out", 32'(bus.clk_out), 32'd0);
    chk("arst.clk_en",  32'(bus.clk_en),  32'd0);
    chk("arst.locked",  32'(bus.locked),  32'd0);
    repeat (2) step();
    chk("arst_hold.clk_out", 32'(bus.clk_out), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) run_vec(v_start[i], "restart", i);
    measure("post_rst", 2, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
